// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//
// Purpose:
//   Moves bytes from a source FIFO to a UART transmitter, one byte at a time.
//   A byte is popped only when the transmitter is idle and no earlier byte is
//   still in flight. The byte is then presented with a one-cycle load strobe.
//   If the transmitter does not raise busy within START_TIMEOUT cycles, the
//   byte is abandoned and drop_out pulses. Completed bytes are counted.
//
// Configuration macro:
//   UART_TX_FEEDER_CRLF_EN
//     When defined, each completed LF (0x0A) is followed by an inserted CR
//     (0x0D). No FIFO pop happens until that CR has completed or has been
//     dropped. When undefined, bytes pass through unmodified.
//
// Parameters:
//   DATA_BITS      width of the byte path (default 8)
//   START_TIMEOUT  cycles allowed for tx_busy_in to rise after a load strobe
//                  (default 32; must be >= 1)
//
// Ports:
//   sysclk         in   clock; all state changes on its rising edge
//   nrst_in        in   asynchronous active-low reset
//   en_in          in   allows new FIFO pops (checked between bytes only)
//   fifo_empty_in  in   source FIFO empty flag
//   fifo_data_in   in   FIFO read data, valid the cycle after fifo_rd_out
//   fifo_rd_out    out  one-cycle FIFO pop strobe
//   tx_busy_in     in   UART transmitter busy for the whole frame
//   tx_data_out    out  byte presented to the transmitter
//   data_rdy_out   out  one-cycle load strobe to the transmitter
//   drop_out       out  one-cycle pulse when a byte is abandoned on timeout
//   tx_count_out   out  bytes completed since reset (wraps at 16 bits)
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DATA_BITS     = 8,
    parameter int START_TIMEOUT = 32
) (
    input  logic                 sysclk,
    input  logic                 nrst_in,
    input  logic                 en_in,
    input  logic                 fifo_empty_in,
    input  logic [DATA_BITS-1:0] fifo_data_in,
    output logic                 fifo_rd_out,
    input  logic                 tx_busy_in,
    output logic [DATA_BITS-1:0] tx_data_out,
    output logic                 data_rdy_out,
    output logic                 drop_out,
    output logic [15:0]          tx_count_out
);

    // The timeout counter must be able to hold START_TIMEOUT itself.
    localparam int TMO_W = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(START_TIMEOUT);

`ifdef UART_TX_FEEDER_CRLF_EN
    localparam logic [DATA_BITS-1:0] CHAR_LF = DATA_BITS'(8'h0A);
    localparam logic [DATA_BITS-1:0] CHAR_CR = DATA_BITS'(8'h0D);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_LOAD       = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_INSERT_CR  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_LOAD       = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] byte_q,  byte_d;
    logic [TMO_W-1:0]     tmo_q,   tmo_d;
    logic [15:0]          count_q, count_d;

    logic pop_req;
    logic load_req;
    logic drop_req;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            tmo_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe logic
    //
    // The pop is decided in IDLE and issued in that same cycle, so the FIFO
    // data shows up while the FSM sits in FETCH, and the load strobe follows
    // in LOAD: pop to load strobe is exactly two cycles.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        tmo_d    = tmo_q;
        count_d  = count_q;
        pop_req  = 1'b0;
        load_req = 1'b0;
        drop_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The empty flag only matters here; the FIFO may change
                // freely while a byte is in flight.
                if (en_in && !fifo_empty_in && !tx_busy_in) begin
                    pop_req = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                byte_d  = fifo_data_in;
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                load_req = 1'b1;
                tmo_d    = '0;
                state_d  = ST_WAIT_START;
            end

            ST_WAIT_START: begin
                // Busy seen on the last allowed cycle still wins over the
                // timeout.
                if (tx_busy_in) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == TMO_LIMIT) begin
                    drop_req = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_WAIT_DONE: begin
                // en_in is deliberately ignored here: a byte already handed
                // to the transmitter always runs to completion.
                if (!tx_busy_in) begin
                    count_d = count_q + 16'd1;
                    state_d = ST_IDLE;
`ifdef UART_TX_FEEDER_CRLF_EN
                    // The inserted CR is never an LF, so it cannot retrigger.
                    if (byte_q == CHAR_LF) begin
                        state_d = ST_INSERT_CR;
                    end
`endif
                end
            end

`ifdef UART_TX_FEEDER_CRLF_EN
            ST_INSERT_CR: begin
                // Reuses the normal load/handshake path, including its
                // timeout; a dropped CR returns straight to IDLE.
                byte_d  = CHAR_CR;
                state_d = ST_LOAD;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    //
    // The pop strobe is a same-cycle decision from IDLE, so a pop can happen
    // in the very first cycle after reset release. Because IDLE is also the
    // reset state, the strobe is additionally qualified by nrst_in to keep it
    // low while reset is held.
    // -------------------------------------------------------------------------
    assign fifo_rd_out  = pop_req & nrst_in;
    assign data_rdy_out = load_req;
    assign drop_out     = drop_req;
    assign tx_data_out  = byte_q;
    assign tx_count_out = count_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    localparam int DW       = 8;
    localparam int TMO      = 32;
    localparam int BUSY_LEN = 10;

    logic          sysclk = 1'b0;
    logic          nrst_in;
    logic          en_in;
    logic          fifo_empty_in;
    logic [DW-1:0] fifo_data_in = '0;
    logic          fifo_rd_out;
    logic          tx_busy_in;
    logic [DW-1:0] tx_data_out;
    logic          data_rdy_out;
    logic          drop_out;
    logic [15:0]   tx_count_out;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 sysclk = ~sysclk;

    uart_tx_feeder #(
        .DATA_BITS     (DW),
        .START_TIMEOUT (TMO)
    ) dut (
        .sysclk        (sysclk),
        .nrst_in       (nrst_in),
        .en_in         (en_in),
        .fifo_empty_in (fifo_empty_in),
        .fifo_data_in  (fifo_data_in),
        .fifo_rd_out   (fifo_rd_out),
        .tx_busy_in    (tx_busy_in),
        .tx_data_out   (tx_data_out),
        .data_rdy_out  (data_rdy_out),
        .drop_out      (drop_out),
        .tx_count_out  (tx_count_out)
    );

    // ---------------- source FIFO model ----------------
    logic [7:0] fifo_mem [0:31];
    logic [4:0] wr_ptr = '0;
    logic [4:0] rd_ptr = '0;

    assign fifo_empty_in = (wr_ptr == rd_ptr);

    always @(posedge sysclk) begin
        if (fifo_rd_out) begin
            fifo_data_in <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 5'd1;
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    // ---------------- UART transmitter model ----------------
    int   busy_left  = 0;
    logic never_busy = 1'b0;

    assign tx_busy_in = (busy_left != 0);

    always @(posedge sysclk) begin
        if (!nrst_in)
            busy_left <= 0;
        else if (data_rdy_out)
            busy_left <= never_busy ? 0 : BUSY_LEN;
        else if (busy_left != 0)
            busy_left <= busy_left - 1;
    end

    // ---------------- event monitor ----------------
    int         cyc           = 0;
    int         rd_seen       = 0;
    int         drop_seen     = 0;
    int         viol          = 0;
    int         last_rd_cyc   = 0;
    int         last_rdy_cyc  = 0;
    int         last_drop_cyc = 0;
    logic       in_flight     = 1'b0;
    logic       prev_busy     = 1'b0;
    logic [7:0] wire_q [$];

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        logic fl;
        fl = in_flight;
        if (!nrst_in) begin
            fl = 1'b0;
        end else begin
            if (prev_busy && !tx_busy_in) fl = 1'b0;
            if (drop_out) begin
                fl = 1'b0;
                drop_seen     <= drop_seen + 1;
                last_drop_cyc <= cyc;
                $display("[%0d] drop", cyc);
            end
            if (fifo_rd_out) begin
                if (fl) viol <= viol + 1;
                fl = 1'b1;
                rd_seen     <= rd_seen + 1;
                last_rd_cyc <= cyc;
            end
            if (data_rdy_out) begin
                wire_q.push_back(tx_data_out);
                last_rdy_cyc <= cyc;
                $display("[%0d] load byte 0x%02h", cyc, tx_data_out);
            end
        end
        in_flight <= fl;
        prev_busy <= tx_busy_in;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #2;
    endtask

    function automatic logic [31:0] wire_at(input int idx);
        if (idx < wire_q.size()) return 32'(wire_q[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_rdy(input string tag, input int budget);
        int k;
        k = 0;
        while (!data_rdy_out && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input int budget);
        int k;
        k = 0;
        while (!tx_busy_in && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    initial begin
        int n_before;
        nrst_in = 1'b0;
        en_in   = 1'b1;

        // Reset with a non-empty FIFO and enable high: no strobes.
        push(8'h41);
        step(3);
        check("rst_fifo_rd",  32'(fifo_rd_out),  32'd0);
        check("rst_data_rdy", 32'(data_rdy_out), 32'd0);
        check("rst_drop",     32'(drop_out),     32'd0);
        check("rst_tx_data",  32'(tx_data_out),  32'd0);
        check("rst_count",    32'(tx_count_out), 32'd0);

        // Single byte 0x41; pop in the first cycle after release.
        @(posedge sysclk);
        #1 nrst_in = 1'b1;
        #1 check("first_pop", 32'(fifo_rd_out), 32'd1);
        step(30);
        check("lat_rd_to_rdy", 32'(last_rdy_cyc - last_rd_cyc), 32'd2);
        check("b41_wire",      wire_at(0),          32'h41);
        check("b41_count",     32'(tx_count_out),   32'd1);
        check("b41_held",      32'(tx_data_out),    32'h41);
        check("b41_no_drop",   32'(drop_seen),      32'd0);

        // Three bytes back to back.
        push(8'h01); push(8'h02); push(8'h03);
        step(80);
        check("seq_b0",     wire_at(1),         32'h01);
        check("seq_b1",     wire_at(2),         32'h02);
        check("seq_b2",     wire_at(3),         32'h03);
        check("seq_count",  32'(tx_count_out),  32'd4);
        check("seq_pops",   32'(rd_seen),       32'd4);
        check("seq_spacing",32'(viol),          32'd0);

        // Transmitter never goes busy: timeout drop.
        never_busy = 1'b1;
        push(8'h77);
        step(45);
        check("tmo_drop_cnt", 32'(drop_seen), 32'd1);
        check("tmo_latency",  32'(last_drop_cyc - last_rdy_cyc), 32'(TMO + 1));
        check("tmo_count",    32'(tx_count_out), 32'd4);
        check("tmo_wire",     wire_at(4), 32'h77);
        never_busy = 1'b0;
        push(8'h78);
        step(30);
        check("post_tmo_wire",  wire_at(5), 32'h78);
        check("post_tmo_count", 32'(tx_count_out), 32'd5);

        // Enable falls during WAIT_DONE.
        push(8'h11); push(8'h12);
        wait_busy("en_busy_bound", 50);
        step(2);
        en_in = 1'b0;
        step(60);
        check("en_cur_done",  32'(tx_count_out), 32'd6);
        check("en_cur_wire",  wire_at(6),        32'h11);
        check("en_no_pop",    32'(rd_seen),      32'd7);
        en_in = 1'b1;
        step(30);
        check("en_resume_wire",  wire_at(7),        32'h12);
        check("en_resume_count", 32'(tx_count_out), 32'd7);
        check("en_resume_pops",  32'(rd_seen),      32'd8);

        // Reset during WAIT_START.
        never_busy = 1'b1;
        push(8'h21);
        wait_rdy("rst_ws_rdy_bound", 20);
        step(5);
        n_before = drop_seen;
        nrst_in = 1'b0;
        #1;
        check("rst_ws_fifo_rd",  32'(fifo_rd_out),  32'd0);
        check("rst_ws_data_rdy", 32'(data_rdy_out), 32'd0);
        check("rst_ws_drop",     32'(drop_out),     32'd0);
        check("rst_ws_tx_data",  32'(tx_data_out),  32'd0);
        check("rst_ws_count",    32'(tx_count_out), 32'd0);
        step(2);
        nrst_in = 1'b1;
        never_busy = 1'b0;
        step(50);
        check("rst_ws_no_drop",  32'(drop_seen),    32'(n_before));
        check("rst_ws_count2",   32'(tx_count_out), 32'd0);

        // Line-ending behaviour.
        push(8'h0A); push(8'h42);
        step(80);
        check("lf_wire0", wire_at(9), 32'h0A);
`ifdef UART_TX_FEEDER_CRLF_EN
        check("lf_wire1",  wire_at(10), 32'h0D);
        check("lf_wire2",  wire_at(11), 32'h42);
        check("lf_count",  32'(tx_count_out), 32'd3);
        check("lf_nbytes", 32'(wire_q.size()), 32'd12);
`else
        check("lf_wire1",  wire_at(10), 32'h42);
        check("lf_count",  32'(tx_count_out), 32'd2);
        check("lf_nbytes", 32'(wire_q.size()), 32'd11);
`endif
        check("final_spacing", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
